// File: rtl/gate_sweep_ctrl.sv
// Sweep sequencer/checker for the 2-input NAND/NOR datapath: steps the four
// input vectors, holds each for DWELL cycles and checks y_in at the end of each hold.
module gate_sweep_ctrl #(
    parameter int DWELL = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       loop,
    input  logic [1:0] y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_vec,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST = 16'(DWELL - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  err_vec_q, err_vec_d;
    logic [2:0]  err_count_q, err_count_d;
    logic        pass_q, pass_d;
    logic [1:0]  exp_y;
    logic        mismatch;

    // a/b come straight from idx_q, so they are registered and read 00 outside RUN
    assign exp_y    = {~(idx_q[1] | idx_q[0]), ~(idx_q[1] & idx_q[0])};
    assign mismatch = (y_in != exp_y);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_vec_d   = err_vec_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;

        case (state_q)
            S_RUN: begin
                if (cnt_q == LAST) begin
                    cnt_d = 16'd0;
                    if (mismatch) begin
                        err_vec_d[idx_q] = 1'b1;
                        err_count_d      = err_count_q + 3'd1;
                    end
                    // idx wraps 3 -> 0 so a/b return to 00 in DONE
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_DONE;
                        pass_d  = (err_count_d == 3'd0);
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new sweep starts from IDLE on start, from DONE on start or loop
        if ((state_q == S_IDLE && start) || (state_q == S_DONE && (start || loop))) begin
            state_d     = S_RUN;
            idx_d       = 2'd0;
            cnt_d       = 16'd0;
            err_vec_d   = 4'd0;
            err_count_d = 3'd0;
            pass_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= 16'd0;
            err_vec_q   <= 4'd0;
            err_count_q <= 3'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_vec_q   <= err_vec_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    assign a         = idx_q[1];
    assign b         = idx_q[0];
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_vec   = err_vec_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: three instances (DWELL 50, 4, 1) driving a faultable
// NAND/NOR datapath, checked every cycle against a sweep-level reference model.
module tb_gate_sweep_ctrl;

    localparam int NI = 3;

    function automatic int dw(int i);
        case (i)
            0:       return 50;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // fault 0: good, 1: stuck 00, 2: NAND inverted, 3: NOR inverted
    function automatic logic [1:0] dp(logic a, logic b, int f);
        logic [1:0] g;
        g = {~(a | b), ~(a & b)};
        case (f)
            1:       return 2'b00;
            2:       return g ^ 2'b01;
            3:       return g ^ 2'b10;
            default: return g;
        endcase
    endfunction

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, loop = 1'b0;
    int   fault = 0;
    int   cyc = 0;
    int   n_vec = 0, n_fail = 0;

    logic       a_w[NI], b_w[NI], busy_w[NI], done_w[NI], pass_w[NI];
    logic [3:0] ev_w[NI];
    logic [2:0] ec_w[NI];
    logic [1:0] y_w[NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        assign y_w[gi] = dp(a_w[gi], b_w[gi], fault);
        gate_sweep_ctrl #(.DWELL(dw(gi))) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .y_in(y_w[gi]),
            .a(a_w[gi]), .b(b_w[gi]), .busy(busy_w[gi]), .done(done_w[gi]),
            .pass(pass_w[gi]), .err_vec(ev_w[gi]), .err_count(ec_w[gi])
        );
    end

    // Reference model: a sweep is "edges since start" plus an error bitmap
    logic [1:0] exp_tab[4] = '{2'b11, 2'b01, 2'b01, 2'b00};
    int       m_t[NI];
    bit       m_run[NI], m_done[NI], m_pass[NI];
    bit [3:0] m_err[NI];

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_err[i] = 0; m_t[i] = 0;
            end else if (m_run[i]) begin
                m_t[i] = m_t[i] + 1;
                if (m_t[i] % dw(i) == 0) begin
                    int k;
                    k = m_t[i] / dw(i) - 1;
                    if (dp(k[1], k[0], fault) != exp_tab[k]) m_err[i][k] = 1'b1;
                    if (k == 3) begin
                        m_run[i] = 0; m_done[i] = 1; m_pass[i] = (m_err[i] == 4'd0);
                    end
                end
            end else begin
                bit go;
                go = m_done[i] ? (start | loop) : start;
                m_done[i] = 0;
                if (go) begin
                    m_run[i] = 1; m_t[i] = 0; m_err[i] = 0; m_pass[i] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic ea, eb, ebusy, edone, epass;
            logic [3:0] eev;
            int v, eec;
            v = m_run[i] ? m_t[i] / dw(i) : 0;
            ea = v[1]; eb = v[0]; ebusy = m_run[i]; edone = m_done[i];
            epass = m_pass[i]; eev = m_err[i]; eec = $countones(m_err[i]);
            if (!rst_n) begin
                ea = 0; eb = 0; ebusy = 0; edone = 0; epass = 0; eev = 0; eec = 0;
            end
            n_vec++;
            if (a_w[i] !== ea || b_w[i] !== eb || busy_w[i] !== ebusy || done_w[i] !== edone ||
                pass_w[i] !== epass || ev_w[i] !== eev || int'(ec_w[i]) != eec) begin
                n_fail++;
                $display("FAIL cycle_cmp inst%0d cyc%0d: got ab=%b%b busy=%b done=%b pass=%b ev=%b ec=%0d, want ab=%b%b busy=%b done=%b pass=%b ev=%b ec=%0d",
                         i, cyc, a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], ev_w[i], ec_w[i],
                         ea, eb, ebusy, edone, epass, eev, eec);
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Returns the edge count at E0 (the edge that samples start)
    task automatic pulse_start(output int e0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(int i, int lim, output int ce);
        ce = -1;
        for (int c = 0; c < lim; c++) begin
            @(negedge clk);
            if (done_w[i] === 1'b1) begin
                ce = cyc;
                break;
            end
        end
    endtask

    initial begin
        int e0, ce;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_ab", {a_w[0], b_w[0]}, 0);
        chk("rst_pass_ev_ec", {pass_w[0], ev_w[0], ec_w[0]}, 0);

        fault = 0;
        pulse_start(e0);
        wait_done(0, 400, ce);
        chk("lat_dw50", ce - e0, 200);
        chk("good_pass", pass_w[0], 1);
        chk("good_ev", ev_w[0], 0);
        chk("good_ec", ec_w[0], 0);

        fault = 1;
        pulse_start(e0);
        wait_done(0, 400, ce);
        chk("stuck_ev", ev_w[0], 4'b0111);
        chk("stuck_ec", ec_w[0], 3);
        chk("stuck_pass", pass_w[0], 0);

        fault = 2;
        pulse_start(e0);
        wait_done(0, 400, ce);
        chk("nandinv_ev", ev_w[0], 4'b1111);
        chk("nandinv_ec", ec_w[0], 4);
        chk("nandinv_pass", pass_w[0], 0);

        // mid-sweep start ignored, then loop rolls straight into a second sweep
        fault = 1;
        pulse_start(e0);
        repeat (70) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #1 loop = 1'b1;
        wait_done(0, 400, ce);
        chk("lat_midstart", ce - e0, 200);
        chk("loop1_ev", ev_w[0], 4'b0111);
        fault = 0;
        @(negedge clk);
        chk("loop_busy", busy_w[0], 1);
        chk("loop_done_low", done_w[0], 0);
        chk("loop_cleared", {ev_w[0], ec_w[0]}, 0);
        loop = 1'b0;
        wait_done(0, 400, ce);
        chk("lat_loop2", ce - (e0 + 201), 200);
        chk("loop2_pass", pass_w[0], 1);
        repeat (3) @(posedge clk);

        // reset during vector 2 of the DWELL=4 instance
        pulse_start(e0);
        while (cyc < e0 + 9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_w[1], 0);
        chk("abort_ab", {a_w[1], b_w[1]}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        pulse_start(e0);
        wait_done(1, 40, ce);
        chk("lat_dw4", ce - e0, 16);
        repeat (3) @(posedge clk);
        pulse_start(e0);
        wait_done(2, 20, ce);
        chk("lat_dw1", ce - e0, 4);

        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 15) == 0);
            loop  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) fault = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        loop  = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
